// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM / memory-mapped I/O controller.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IO,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } mem_state_t;

  localparam logic [15:0] DEFAULT_IO_ADDR = 16'hFFFF;
  localparam int          WAIT_CNT_W      = 4;

  // The wait counter is 4 bits wide and must run for at least one cycle.
  function automatic bit wait_states_ok(input int ws);
    return (ws >= 1) && (ws <= 15);
  endfunction

endpackage

// File: rtl/sram_bidir_buf.sv
// Bidirectional SRAM data pad: holds the write word in a register and drives it
// onto the bus only while its output enable is set.
module sram_bidir_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data,
  inout  wire  [DATA_W-1:0] pad
);

  logic [DATA_W-1:0] wdata_q;
  logic              oe_q;

  // load wins over drop so a new write can never lose its bus ownership.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q <= '0;
      oe_q    <= 1'b0;
    end else if (load) begin
      wdata_q <= wdata;
      oe_q    <= 1'b1;
    end else if (drop) begin
      oe_q    <= 1'b0;
    end
  end

  assign pad     = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign rd_data = pad;

endmodule

// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory controller: req/ack front end, wait-stated async SRAM access with
// byte lanes, and one I/O address (switches / hex register). Option: SW_SYNC_EN.
//
// state  | meaning
// IDLE   | waiting for req; SRAM strobes released
// IO     | switch/hex access completed, ack high
// SETUP  | CE_N low, address and lanes set up, write data on bus
// ACCESS | OE_N or WE_N asserted for WAIT_STATES cycles
// DONE   | strobes off, CE_N and write data held, ack high
module slc3_mem_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int                    ADDR_W      = 20,
  parameter int                    CPU_ADDR_W  = 16,
  parameter int                    DATA_W      = 16,
  parameter int                    WAIT_STATES = 2,
  parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = CPU_ADDR_W'(DEFAULT_IO_ADDR)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [CPU_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  busy,
  output logic                  req_drop,
  input  logic [DATA_W-1:0]     Switches,
  output logic [DATA_W-1:0]     hex_data,
  output logic                  CE_N,
  output logic                  OE_N,
  output logic                  WE_N,
  output logic [DATA_W/8-1:0]   BE_N,
  output logic [ADDR_W-1:0]     ADDR,
  inout  wire  [DATA_W-1:0]     Data
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = WAIT_CNT_W'(WAIT_STATES - 1);

  if (!wait_states_ok(WAIT_STATES)) begin : g_bad_wait_states
    $error("slc3_mem_ctrl: WAIT_STATES must be within 1..15");
  end
  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("slc3_mem_ctrl: DATA_W must be a non-zero multiple of 8");
  end

  mem_state_t              state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    we_q;
  logic [DATA_W-1:0]       sw_src;
  logic [DATA_W-1:0]       bus_rd;
  logic                    is_io;
  logic                    wr_start;
  logic                    bus_drop;

`ifdef SW_SYNC_EN
  logic [DATA_W-1:0] sw_meta;
  logic [DATA_W-1:0] sw_sync;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= Switches;
      sw_sync <= sw_meta;
    end
  end

  assign sw_src = sw_sync;
`else
  assign sw_src = Switches;
`endif

  assign is_io    = (addr == IO_ADDR);
  assign wr_start = (state == ST_IDLE) && req && we && !is_io;
  assign bus_drop = (state == ST_DONE);

  sram_bidir_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk    (Clk),
    .rst_n  (Reset),
    .load   (wr_start),
    .drop   (bus_drop),
    .wdata  (wdata),
    .rd_data(bus_rd),
    .pad    (Data)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      CE_N     <= 1'b1;
      OE_N     <= 1'b1;
      WE_N     <= 1'b1;
      BE_N     <= '1;
      ADDR     <= '0;
      rdata    <= '0;
      hex_data <= '0;
      ack      <= 1'b0;
      busy     <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      ack      <= 1'b0;
      req_drop <= req && (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (is_io) begin
              // I/O completes on this edge so rdata/hex are valid alongside ack.
              state <= ST_IO;
              ack   <= 1'b1;
              if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                  if (be[i]) hex_data[8*i +: 8] <= wdata[8*i +: 8];
                end
              end else begin
                rdata <= sw_src;
              end
            end else begin
              state    <= ST_SETUP;
              we_q     <= we;
              ADDR     <= ADDR_W'(addr);
              CE_N     <= 1'b0;
              wait_cnt <= CNT_LOAD;
              if (we) begin
                BE_N <= ~be;
              end else begin
                OE_N <= 1'b0;
                BE_N <= '0;
              end
            end
          end
        end
        ST_IO: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
          if (we_q) WE_N <= 1'b0;
        end
        ST_ACCESS: begin
          if (wait_cnt == '0) begin
            state <= ST_DONE;
            WE_N  <= 1'b1;
            OE_N  <= 1'b1;
            ack   <= 1'b1;
            if (!we_q) rdata <= bus_rd;
          end else begin
            wait_cnt <= wait_cnt - CNT_ONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          CE_N  <= 1'b1;
          BE_N  <= '1;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Scoreboard bench for slc3_mem_ctrl: directed protocol checks, then random traffic
// against an array-based memory/IO reference model.
module tb_slc3_mem_ctrl;

  localparam int          WS      = 2;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = '0;
  logic [15:0] Switches = '0;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic        req_drop;
  logic [15:0] hex_data;
  logic        CE_N;
  logic        OE_N;
  logic        WE_N;
  logic [1:0]  BE_N;
  logic [19:0] ADDR;
  wire  [15:0] data_bus;

  slc3_mem_ctrl #(
    .ADDR_W(20), .CPU_ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS), .IO_ADDR(IO_ADDR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata), .ack(ack), .busy(busy), .req_drop(req_drop),
    .Switches(Switches), .hex_data(hex_data),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .BE_N(BE_N), .ADDR(ADDR), .Data(data_bus)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // Async SRAM model: drives the bus on OE, captures enabled lanes while WE is low.
  logic [15:0] sram [0:63];
  logic        sram_init = 1'b0;
  assign data_bus = (!CE_N && !OE_N) ? sram[ADDR[5:0]] : 16'hzzzz;

  function automatic logic [15:0] f_init(input int i);
    return {8'(i * 3 + 64), 8'(i ^ 8'hC5)};
  endfunction

  always @(posedge Clk) begin
    if (sram_init) begin
      for (int i = 0; i < 64; i++) sram[i] <= f_init(i);
    end else if (!CE_N && !WE_N) begin
      if (!BE_N[0]) sram[ADDR[5:0]][7:0]  <= data_bus[7:0];
      if (!BE_N[1]) sram[ADDR[5:0]][15:8] <= data_bus[15:8];
    end
  end

  // Reference model
  logic [15:0] ref_mem [0:63];
  logic [15:0] ref_hex = '0;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] b);
    logic [15:0] r;
    r = old;
    if (b[0]) r[7:0]  = nw[7:0];
    if (b[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;
  int ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    bit          chk_rd;
    bit          chk_hex;
    logic [15:0] exp;
    int          exp_cyc;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge Clk) begin : monitor
    sb_t e;
    if (Reset && ack) begin
      ack_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_latency"}, 32'(cyc), 32'(e.exp_cyc));
        if (e.chk_rd)  chk({e.name, "_rdata"}, 32'(rdata), 32'(e.exp));
        if (e.chk_hex) chk({e.name, "_hex"}, 32'(hex_data), 32'(e.exp));
      end
    end
  end

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] wd,
                       input logic [1:0] b, input bit push, input logic [15:0] io_exp,
                       input string nm);
    sb_t e;
    @(posedge Clk); #1;
    req = 1'b1; we = w; addr = a; wdata = wd; be = b;
    if (push) begin
      e.name = nm; e.chk_rd = 1'b0; e.chk_hex = 1'b0; e.exp = '0;
      if (a == IO_ADDR) begin
        e.exp_cyc = cyc + 1;
        if (w) begin
          ref_hex = merge(ref_hex, wd, b);
          e.chk_hex = 1'b1; e.exp = ref_hex;
        end else begin
          e.chk_rd = 1'b1; e.exp = io_exp;
        end
      end else begin
        e.exp_cyc = cyc + WS + 2;
        if (w) ref_mem[a[5:0]] = merge(ref_mem[a[5:0]], wd, b);
        else begin
          e.chk_rd = 1'b1; e.exp = ref_mem[a[5:0]];
        end
      end
      sb_q.push_back(e);
    end
    @(posedge Clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic observe(input int n, input logic [15:0] wd, output int oe_lo, output int we_lo,
                         output int ce_hi, output int d_ok, output logic [1:0] be_first,
                         output logic [19:0] addr_first);
    oe_lo = 0; we_lo = 0; ce_hi = 0; d_ok = 0; be_first = '0; addr_first = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (!OE_N) oe_lo++;
      if (!WE_N) we_lo++;
      if (CE_N) ce_hi++;
      if (data_bus === wd) d_ok++;
      if (i == 0) begin
        be_first = BE_N; addr_first = ADDR;
      end
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int oe_lo, we_lo, ce_hi, d_ok, acks0;
    logic [1:0]  be_f;
    logic [19:0] addr_f;
    logic [15:0] a, wd;
    logic        w;

    for (int i = 0; i < 64; i++) ref_mem[i] = f_init(i);
    sram_init = 1'b1;
    @(negedge Clk);
    chk("rst_strobes", {28'd0, CE_N, OE_N, WE_N, 1'b0}, 32'hE);
    chk("rst_be_n", 32'(BE_N), 32'h3);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_rdata_hex", {rdata, hex_data}, 32'd0);
    chk("rst_flags", {29'd0, ack, busy, req_drop}, 32'd0);
    @(negedge Clk);
    sram_init = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Read 0x0030 holding BEEF
    issue(1'b1, 16'h0030, 16'hBEEF, 2'b11, 1'b1, '0, "wr_beef");
    wait_idle();
    issue(1'b0, 16'h0030, '0, 2'b00, 1'b1, '0, "rd_beef");
    observe(WS + 2, 16'h0000, oe_lo, we_lo, ce_hi, d_ok, be_f, addr_f);
    chk("rd_addr", 32'(addr_f), 32'h00030);
    chk("rd_oe_low_cycles", 32'(oe_lo), 32'(WS + 1));
    chk("rd_be_n", 32'(be_f), 32'h0);
    wait_idle();
    chk("rd_rdata_held", 32'(rdata), 32'h0000BEEF);

    // Low-byte write
    issue(1'b1, 16'h0010, 16'h1234, 2'b01, 1'b1, '0, "wr_lb");
    observe(WS + 2, 16'h1234, oe_lo, we_lo, ce_hi, d_ok, be_f, addr_f);
    chk("wr_be_n", 32'(be_f), 32'h2);
    chk("wr_we_low_cycles", 32'(we_lo), 32'(WS));
    chk("wr_oe_low_cycles", 32'(oe_lo), 32'd0);
    chk("wr_data_driven", 32'(d_ok), 32'(WS + 2));
    wait_idle();
    chk("wr_sram_word", 32'(sram[16]), 32'({f_init(16)[15:8], 8'h34}));

    // I/O port
    Switches = 16'h00A5;
    repeat (3) @(posedge Clk);
    issue(1'b0, IO_ADDR, '0, 2'b00, 1'b1, 16'h00A5, "io_rd");
    observe(2, 16'h0000, oe_lo, we_lo, ce_hi, d_ok, be_f, addr_f);
    chk("io_ce_untouched", 32'(ce_hi), 32'd2);
    wait_idle();
    issue(1'b1, IO_ADDR, 16'hC0DE, 2'b11, 1'b1, '0, "io_wr");
    wait_idle();
    chk("io_hex_full", 32'(hex_data), 32'h0000C0DE);
    issue(1'b1, IO_ADDR, 16'h1100, 2'b10, 1'b1, '0, "io_wr_hi");
    wait_idle();
    chk("io_hex_hi_lane", 32'(hex_data), 32'h000011DE);

    // req while busy
    acks0 = ack_cnt;
    issue(1'b0, 16'h0030, '0, 2'b00, 1'b1, '0, "rd_with_drop");
    @(posedge Clk); #1;
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hDEAD; be = 2'b11;
    @(posedge Clk); #1;
    req = 1'b0;
    @(negedge Clk);
    chk("req_drop_pulse", 32'(req_drop), 32'd1);
    @(negedge Clk);
    chk("req_drop_clear", 32'(req_drop), 32'd0);
    wait_idle();
    repeat (3) @(negedge Clk);
    chk("drop_single_ack", 32'(ack_cnt - acks0), 32'd1);
    chk("drop_no_write", 32'(sram[32]), 32'(ref_mem[32]));

    // Reset in the middle of a write's ACCESS phase
    acks0 = ack_cnt;
    issue(1'b1, 16'h003F, 16'h5555, 2'b11, 1'b0, '0, "abort");
    @(posedge Clk); #1;
    chk("abort_we_active", 32'(WE_N), 32'd0);
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_strobes", {30'd0, WE_N, CE_N}, 32'h3);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bus_released", 32'(data_bus === 16'h5555), 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    repeat (6) @(negedge Clk);
    chk("abort_no_ack", 32'(ack_cnt - acks0), 32'd0);
    chk("abort_hex_cleared", 32'(hex_data), 32'd0);
    ref_hex = '0;

`ifdef SW_SYNC_EN
    Switches = 16'h0000;
    repeat (4) @(posedge Clk);
    #1;
    Switches = 16'h0003;
    issue(1'b0, IO_ADDR, '0, 2'b00, 1'b1, 16'h0000, "sync_old");
    wait_idle();
    @(posedge Clk); #1;
    Switches = 16'h0005;
    repeat (2) @(posedge Clk);
    issue(1'b0, IO_ADDR, '0, 2'b00, 1'b1, 16'h0005, "sync_new");
    wait_idle();
`endif

    // Random traffic
    for (int t = 0; t < 80; t++) begin
      Switches = 16'($urandom);
      repeat ($urandom_range(3, 5)) @(posedge Clk);
      a  = ($urandom_range(0, 7) == 0) ? IO_ADDR : 16'($urandom_range(0, 62));
      w  = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      issue(w, a, wd, 2'($urandom_range(0, 3)), 1'b1, Switches, "rnd");
      if (a != IO_ADDR && $urandom_range(0, 3) == 0) begin
        @(posedge Clk); #1;
        req = 1'b1; we = 1'b1; addr = 16'($urandom_range(0, 62)); wdata = 16'($urandom);
        be = 2'b11;
        @(posedge Clk); #1;
        req = 1'b0;
      end
      wait_idle();
    end
    repeat (4) @(negedge Clk);
    for (int i = 0; i < 63; i += 9) chk("final_mem", 32'(sram[i]), 32'(ref_mem[i]));
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/slc3_mem_ctrl.md
Name: slc3_mem_ctrl

Overview:
Parametrised SRAM and memory-mapped I/O controller for the SLC-3 datapath. It sits between the CPU memory port (MAR/MDR side) and the external async SRAM. It replaces fixed-timing memory control with a req/ack handshake, configurable wait states and byte-lane writes. One address is decoded as I/O: reads return switches, writes load a hex-display register.

Parameters:
ADDR_W, 20, SRAM address width; CPU address zero-extended into it.
CPU_ADDR_W, 16, CPU address width.
DATA_W, 16, data width; must be a multiple of 8.
WAIT_STATES, 2, ACCESS-phase cycles; legal 1..15; 0 is an elaboration error.
IO_ADDR, 16'hFFFF, CPU address decoded as the switch/hex I/O port.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
req  in  1  single-cycle request pulse from the CPU FSM
we  in  1  1=write, 0=read; sampled with req
addr  in  CPU_ADDR_W  request address; sampled with req
wdata  in  DATA_W  write data; sampled with req
be  in  DATA_W/8  byte enables for writes; sampled with req
rdata  out  DATA_W  registered read data; valid while ack=1 and held until the next read completes
ack  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
req_drop  out  1  one-cycle pulse when req arrives while busy; that request is ignored
Switches  in  DATA_W  board switches
hex_data  out  DATA_W  I/O write register, feeds the HexDrivers
CE_N, OE_N, WE_N  out  1 each  SRAM strobes, active-low
BE_N  out  DATA_W/8  SRAM byte lanes (UB_N/LB_N when DATA_W=16), active-low
ADDR  out  ADDR_W  SRAM address
Data  inout  DATA_W  SRAM data bus (wire)

Behaviour:
- Reset (async, Reset=0): state=IDLE. CE_N, OE_N, WE_N and BE_N all 1. ADDR=0, rdata=0, hex_data=0, ack=0, busy=0, req_drop=0. Data is high-Z. Takes effect immediately even mid-access; no ack is issued for an aborted access.
- States: IDLE, IO, SETUP, ACCESS, DONE.
- IDLE + req with addr==IO_ADDR goes to IO.
- IDLE + req with any other addr goes to SETUP. addr, we, wdata and be are latched; the latched address drives ADDR.
- IO: for a read, rdata<=Switches. For a write, hex_data<=wdata; bytes with be=0 are unchanged. ack=1. Next state IDLE. Latency is 1 cycle from the req edge to ack. SRAM strobes are not touched.
- SETUP (1 cycle): CE_N=0. Read: OE_N=0, BE_N=all 0. Write: Data driven with the latched wdata, BE_N=~be, WE_N stays 1. The wait counter is loaded with WAIT_STATES-1.
- ACCESS: strobes held. Write: WE_N=0. The counter decrements each cycle; at 0 go to DONE. Read: rdata<=Data on the edge leaving the last ACCESS cycle.
- DONE (1 cycle): WE_N=1, OE_N=1, CE_N=0. Write data stays driven as hold time. ack=1. Next state IDLE, which releases CE_N, BE_N and Data.
- SRAM latency: ack is asserted WAIT_STATES+2 cycles after the req cycle.
- req in any non-IDLE state: ignored, req_drop=1 for that cycle, current access unaffected.
- Data is driven only in SETUP, ACCESS and DONE of a write, and never in the same cycle as OE_N=0.
- Address mapping: ADDR = zero-extended latched addr. If CPU_ADDR_W > ADDR_W, the upper bits are truncated.

Optional Feature:
SW_SYNC_EN: when defined, Switches pass through a 2-flop synchronizer reset to 0, and IO reads return the synchronized value (2-cycle input lag). When undefined, Switches are sampled directly in IO.

Decomposition:
- Package slc3_mem_pkg: state enum typedef mem_state_t, default IO_ADDR constant, WAIT_STATES legality check function.
- One sub-module, sram_bidir_buf: DATA_W-parametrised tristate with registered write data and an output enable.
- Counter and FSM stay in slc3_mem_ctrl.

Test Plan:
- Reset=0 mid-ACCESS of a write -> same cycle WE_N=CE_N=1, Data=Z; no ack afterward; ack=0 until the next req.
- WAIT_STATES=2, read addr 16'h0030 with SRAM model holding 16'hBEEF -> ADDR=20'h00030, OE_N low 3 cycles, ack at cycle 4 after req, rdata=16'hBEEF.
- Write addr 16'h0010, wdata 16'h1234, be=2'b01 -> LB_N=0, UB_N=1, WE_N low exactly WAIT_STATES cycles, Data=16'h1234 from SETUP through DONE; model low byte=34, high byte unchanged.
- Read IO_ADDR with Switches=16'h00A5 -> ack one cycle later, rdata=16'h00A5, CE_N stays 1. Write IO_ADDR 16'hC0DE with be=2'b11 -> hex_data=16'hC0DE.
- req pulsed during ACCESS -> req_drop=1 for that cycle, first access completes normally, exactly one ack.
- SW_SYNC_EN defined, Switches changed to 16'h0003 then IO read 1 cycle later -> old value returned; read 3 cycles later -> 16'h0003.
